// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants and state encoding for the shift-add 4x3 multiplier controller.
package shift_add_mult_ctrl_pkg;

  localparam int unsigned AW = 4;
  localparam int unsigned BW = 3;
  localparam int unsigned PW = AW + BW;

  localparam logic [1:0] CntLast = 2'(BW - 1);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/shift_add_mult_ctrl_four_adder.sv
// 4-bit ripple-carry adder, the single arithmetic resource shared by every iteration.
module shift_add_mult_ctrl_four_adder
  import shift_add_mult_ctrl_pkg::*;
(
  input  logic [AW-1:0] a,
  input  logic [AW-1:0] b,
  input  logic          cin,
  output logic [AW-1:0] sum,
  output logic          cout
);

  logic [AW:0] carry;

  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < int'(AW); i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
    cout = carry[AW];
  end

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential 4x3 unsigned multiplier: one shared adder, three shift-add steps per product,
// registered product and a one-cycle done strobe.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] a,
  input  logic [BW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [PW-1:0] product
);

  state_e        state_q, state_d;
  logic [AW-1:0] mcand_q, mcand_d;
  // {hi, lo}; the carry bit above hi is always shifted out as zero, so it is not stored.
  logic [PW-1:0] work_q, work_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [PW-1:0] product_q, product_d;

  logic [AW-1:0] add_b, add_sum;
  logic          add_cout;

  assign add_b = work_q[0] ? mcand_q : '0;

  shift_add_mult_ctrl_four_adder u_adder (
    .a    (work_q[PW-1:BW]),
    .b    (add_b),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      mcand_q   <= '0;
      work_q    <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      work_q    <= work_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    work_d    = work_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      StCalc: begin
        work_d = {add_cout, add_sum, work_q[BW-1:1]};
        cnt_d  = cnt_q + 2'd1;
        if (cnt_q == CntLast) begin
          product_d = work_d;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      // StIdle and the unused encoding behave identically.
      default: begin
        state_d = StIdle;
        if (start) begin
          mcand_d = a;
          work_d  = {{AW{1'b0}}, b};
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
    endcase
  end

  always_comb begin
    busy    = (state_q == StCalc) || (state_q == StDone);
    done    = (state_q == StDone);
    product = product_q;
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench: vector table, hand sequences, exhaustive and random sweeps vs a*b.
module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] a;
  logic [2:0] b;
  logic       busy;
  logic       done;
  logic [6:0] product;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  logic [6:0] last_prod = '0;

  shift_add_mult_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [2:0] b;
    logic [6:0] prod;
    bit         noise;
  } vec_t;

  vec_t vecs[8];

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    else pass_cnt++;
  endtask

  // Full transaction from IDLE; noise=1 also fires ignored start requests while busy.
  task automatic run_mult(input logic [3:0] ta, input logic [2:0] tb_, input bit noise);
    logic [6:0] exp;
    exp = 7'(int'(ta) * int'(tb_));
    a = ta;
    b = tb_;
    start = 1'b1;
    step();
    check("busy_after_accept", busy, 1);
    check("done_at_accept", done, 0);
    start = noise;
    a = 4'($urandom);
    b = 3'($urandom);
    for (int i = 0; i < 2; i++) begin
      step();
      check("done_in_calc", done, 0);
      check("busy_in_calc", busy, 1);
      check("product_held_calc", product, last_prod);
    end
    step();
    check("done_strobe", done, 1);
    check("product", product, exp);
    last_prod = exp;
    start = noise;
    step();
    start = 1'b0;
    check("busy_after_done", busy, 0);
    check("done_one_cycle", done, 0);
    check("product_held_idle", product, exp);
    if (noise) begin
      step();
      check("no_queued_start", busy, 0);
      check("product_still", product, exp);
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'd15, b: 3'd7, prod: 7'd105, noise: 1'b0};
    vecs[1] = '{a: 4'd13, b: 3'd3, prod: 7'd39,  noise: 1'b0};
    vecs[2] = '{a: 4'd0,  b: 3'd5, prod: 7'd0,   noise: 1'b0};
    vecs[3] = '{a: 4'd9,  b: 3'd0, prod: 7'd0,   noise: 1'b0};
    vecs[4] = '{a: 4'd6,  b: 3'd5, prod: 7'd30,  noise: 1'b1};
    vecs[5] = '{a: 4'd5,  b: 3'd3, prod: 7'd15,  noise: 1'b0};
    vecs[6] = '{a: 4'd1,  b: 3'd1, prod: 7'd1,   noise: 1'b1};
    vecs[7] = '{a: 4'd15, b: 3'd0, prod: 7'd0,   noise: 1'b0};

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    step();
    step();
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_product", product, 0);
    rst = 1'b0;
    step();

    // Table vectors: expected product is the table constant, not the model.
    foreach (vecs[i]) begin
      a = vecs[i].a;
      b = vecs[i].b;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("vec_done", done, 1);
      check("vec_product", product, vecs[i].prod);
      last_prod = vecs[i].prod;
      start = vecs[i].noise;
      a = 4'd1;
      b = 3'd1;
      step();
      start = 1'b0;
      check("vec_idle", busy, 0);
    end

    run_mult(4'd6, 3'd5, 1'b1);

    // Continuous start: new acceptance right after each DONE, alternating operands.
    begin
      logic [6:0] expq[$];
      int last_done;
      int n;
      last_done = -1;
      a = 4'd2;
      b = 3'd1;
      expq.push_back(7'd2);
      start = 1'b1;
      for (int k = 0; k < 4; k++) begin
        n = 0;
        while (!done && n < 12) begin
          step();
          n++;
        end
        check("cont_done_seen", done, 1);
        check("cont_product", product, expq.pop_front());
        if (last_done >= 0) check("cont_period", cyc - last_done, 5);
        last_done = cyc;
        if (k % 2 == 0) begin
          a = 4'd3;
          b = 3'd2;
          expq.push_back(7'd6);
        end else begin
          a = 4'd2;
          b = 3'd1;
          expq.push_back(7'd2);
        end
        if (k == 3) start = 1'b0;
        step();
      end
      check("cont_end_idle", busy, 0);
      last_prod = 7'd6;
    end

    // Reset during the second CALC cycle discards the result.
    begin
      int dones;
      a = 4'd15;
      b = 3'd7;
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_product", product, 0);
      last_prod = '0;
      dones = 0;
      for (int i = 0; i < 4; i++) begin
        step();
        if (done) dones++;
      end
      check("rst_no_done", dones, 0);
      run_mult(4'd5, 3'd3, 1'b0);
    end

    for (int i = 0; i < 128; i++) run_mult(4'(i >> 3), 3'(i), 1'b0);

    for (int i = 0; i < 40; i++) begin
      int gap;
      run_mult(4'($urandom), 3'($urandom), bit'($urandom_range(0, 1)));
      gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) begin
        step();
        check("rand_idle_held", product, last_prod);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
